// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a main+skid buffer, increment transform,
// synchronous flush and a wrapping downstream-transfer counter.
module pipe_stage_skid #(
    parameter int DATA_W = 16,
    parameter int INC    = 1,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_internal_stall,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_xfer_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] xform;
    logic              acc;
    logic              out;

    assign xform       = i_data + DATA_W'(INC);
    assign o_ready     = ~i_internal_stall & (state_q != FULL);
    assign o_valid     = (state_q != EMPTY);
    assign acc         = i_valid & o_ready;
    assign out         = o_valid & i_ready;
    assign o_data      = main_q;
    assign o_occupancy = state_q;
    assign o_xfer_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = BUSY;
                    main_d  = xform;
                end
            end
            BUSY: begin
                unique case (1'b1)
                    acc & out: main_d = xform;
                    acc & ~out: begin
                        state_d = FULL;
                        skid_d  = xform;
                    end
                    ~acc & out: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (out) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush drops everything; stale data in main/skid is never exposed
        if (i_flush)
            state_d = EMPTY;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_q + CNT_W'(out);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid against a queue-based
// model of a 2-deep ordered buffer.
module tb_pipe_stage_skid;

    localparam int DW  = 16;
    localparam int CW  = 2;
    localparam int INC = 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          stall;
    logic [DW-1:0] din;
    logic          vin;
    logic          rdy_out;
    logic [DW-1:0] dout;
    logic          vout;
    logic          rdy_in;
    logic [1:0]    occ;
    logic [CW-1:0] cnt;

    pipe_stage_skid #(
        .DATA_W(DW),
        .INC   (INC),
        .CNT_W (CW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_flush         (flush),
        .i_internal_stall(stall),
        .i_data          (din),
        .i_valid         (vin),
        .o_ready         (rdy_out),
        .o_data          (dout),
        .o_valid         (vout),
        .i_ready         (rdy_in),
        .o_occupancy     (occ),
        .o_xfer_cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_q[$];
    int            m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        vin   = 1'b0;
        din   = '0;
        rdy_in = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        #2 rst_n = 1'b0;
        m_q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // drive one cycle, check outputs against the model, advance the model
    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic r, input logic s, input logic f);
        logic acc;
        logic out;
        int   sz;
        @(negedge clk);
        vin    = v;
        din    = d;
        rdy_in = r;
        stall  = s;
        flush  = f;
        #1;
        sz = m_q.size();
        chk("valid", 32'(vout), 32'(sz != 0));
        chk("ready", 32'(rdy_out), 32'(!s && sz < 2));
        chk("occ", 32'(occ), 32'(sz));
        chk("cnt", 32'(cnt), 32'(m_cnt % (1 << CW)));
        if (sz != 0)
            chk("data", 32'(dout), 32'(m_q[0]));
        acc = v && !s && sz < 2;
        out = (sz != 0) && r;
        @(posedge clk);
        if (out) begin
            void'(m_q.pop_front());
            m_cnt++;
        end
        if (f)
            m_q.delete();
        else if (acc)
            m_q.push_back(DW'(d + INC));
    endtask

    initial begin
        rst_n = 1'b1;
        do_reset();
        #1;
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);

        // single transfer, 1-cycle latency
        step(1, 16'h0010, 1, 0, 0);
        #1;
        chk("t1_valid", 32'(vout), 32'd1);
        chk("t1_data", 32'(dout), 32'h0011);
        step(0, 0, 1, 0, 0);
        #1;
        chk("t1_cnt", 32'(cnt), 32'd1);

        // back-pressure fills skid, then drains in order
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        #1;
        chk("t2_occ", 32'(occ), 32'd2);
        chk("t2_ready", 32'(rdy_out), 32'd0);
        chk("t2_data", 32'(dout), 32'h0002);
        step(0, 0, 1, 0, 0);
        #1;
        chk("t2_data2", 32'(dout), 32'h0003);
        step(0, 0, 1, 0, 0);

        // transform wraps
        step(1, 16'hFFFF, 0, 0, 0);
        #1;
        chk("t3_data", 32'(dout), 32'h0000);
        chk("t3_valid", 32'(vout), 32'd1);
        step(0, 0, 1, 0, 0);

        // flush while full
        step(1, 16'h0005, 0, 0, 0);
        step(1, 16'h0006, 0, 0, 0);
        step(1, 16'h0007, 0, 0, 1);
        #1;
        chk("t4_valid", 32'(vout), 32'd0);
        chk("t4_occ", 32'(occ), 32'd0);
        chk("t4_ready", 32'(rdy_out), 32'd1);
        chk("t4_cnt", 32'(cnt), 32'(m_cnt % 4));

        // stall blocks acceptance but not draining
        step(1, 16'h0007, 0, 0, 0);
        step(1, 16'h0008, 1, 1, 0);
        #1;
        chk("t5_occ", 32'(occ), 32'd0);
        chk("t5_valid", 32'(vout), 32'd0);

        // counter wrap over a burst, then async reset mid-burst
        do_reset();
        step(1, 16'h0100, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, DW'(16'h0101 + i), 1, 0, 0);
            #1;
            chk("t6_cnt", 32'(cnt), 32'((i + 1) % 4));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(vout), 32'd0);
        chk("t6_async_occ", 32'(occ), 32'd0);
        chk("t6_async_cnt", 32'(cnt), 32'd0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0);
        end
        step(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
